// File: rtl/cmm_pkg.sv
// Shared types for the complex dot-product scheduling slice: scheduler
// state encoding, the complex result word and the operand beat.
package cmm_pkg;

  // Scheduler batch states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    FLUSH = 2'd3
  } sched_state_e;

  // One complex value as returned by the engine: {imag, real}.
  typedef struct packed {
    logic [63:0] imag;
    logic [63:0] re;
  } cplx_t;

  // Default operand beat: OP_SIZE pairs of {b2, a2, b1, a1}, 64 bits each.
  localparam int OP_SIZE = 16;
  localparam int OPW     = OP_SIZE * 4 * 64;
  typedef logic [OPW-1:0] op_beat_t;

endpackage : cmm_pkg

// File: rtl/complex_dot_scheduler.sv
// Batch scheduler for the pipelined complex dot-product engine. Forwards
// operand beats to the engine while bounding the jobs in flight, tags each
// returned result with its job index, and reports batch completion/abort.
// Operand and result data are pure wires; only control is registered.
module complex_dot_scheduler
  import cmm_pkg::*;
#(
  parameter int SIZE         = 16,
  parameter int MAX_INFLIGHT = 8,
  parameter int LEN_W        = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [LEN_W-1:0]      cmd_len_i,
  input  logic                  abort_i,
  input  logic                  op_valid_i,
  output logic                  op_ready_o,
  input  logic [SIZE*4*64-1:0]  op_data_i,
  output logic                  eng_valid_o,
  input  logic                  eng_ready_i,
  output logic [SIZE*4*64-1:0]  eng_operands_o,
  output logic                  eng_flush_o,
  input  logic                  eng_res_valid_i,
  output logic                  eng_res_ready_o,
  input  logic [127:0]          eng_res_i,
  output logic                  res_valid_o,
  input  logic                  res_ready_i,
  output logic [127:0]          res_data_o,
  output logic [LEN_W-1:0]      res_idx_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  aborted_o,
  output logic                  err_o
);

  // One extra bit so the counter can hold MAX_INFLIGHT itself.
  localparam int IW = $clog2(MAX_INFLIGHT) + 1;

  sched_state_e     state_q, state_d;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] issued_q;
  logic [LEN_W-1:0] retired_q;
  logic [IW-1:0]    inflight_q;
  logic             done_q, done_d;
  logic             aborted_q, aborted_d;
  logic             err_q;

  logic             active;
  logic             cmd_fire;
  logic             can_issue;
  logic             issue_fire;
  logic             spurious;
  logic             retire_fire;
  logic             last_issue;
  logic             last_retire;
  cplx_t            res_word;

  assign active    = (state_q == RUN) || (state_q == DRAIN);
  assign cmd_fire  = cmd_valid_i && (state_q == IDLE);
  assign can_issue = (state_q == RUN) && (issued_q < len_q)
                     && (inflight_q < IW'(MAX_INFLIGHT));

  // Issue path: combinational handshake pass-through gated by can_issue.
  assign eng_valid_o    = op_valid_i && can_issue;
  assign op_ready_o     = eng_ready_i && can_issue;
  assign issue_fire     = op_valid_i && op_ready_o;
  assign eng_operands_o = op_data_i;

  // A result with nothing in flight cannot belong to any job: swallow it.
  assign spurious        = active && eng_res_valid_i && (inflight_q == '0);
  assign res_valid_o     = active && eng_res_valid_i && !spurious;
  assign eng_res_ready_o = (active && (res_ready_i || spurious))
                           || (state_q == FLUSH);
  assign retire_fire     = res_valid_o && res_ready_i;

  // Results come back in order, so the retire count is the job index.
  assign res_word   = eng_res_i;
  assign res_data_o = res_word;
  assign res_idx_o  = retired_q;

  assign last_issue  = issue_fire  && ((issued_q  + LEN_W'(1)) == len_q);
  assign last_retire = retire_fire && ((retired_q + LEN_W'(1)) == len_q);

  assign cmd_ready_o = (state_q == IDLE);
  assign busy_o      = (state_q != IDLE);
  assign eng_flush_o = (state_q == FLUSH);
  assign done_o      = done_q;
  assign aborted_o   = aborted_q;
  assign err_o       = err_q;

  // State register plus the registered one-cycle completion flags.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
    end
  end

  // Next-state and completion-pulse decode; abort outranks issue/retire.
  // NOTE: every output of this block gets a default first, so no path
  // through the case can leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    done_d    = 1'b0;
    aborted_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cmd_fire) begin
          if (cmd_len_i == '0) done_d  = 1'b1;
          else                 state_d = RUN;
        end
      end
      RUN: begin
        if (abort_i)         state_d = FLUSH;
        else if (last_issue) state_d = DRAIN;
      end
      DRAIN: begin
        if (abort_i) begin
          state_d = FLUSH;
        end else if (last_retire) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      FLUSH: begin
        state_d   = IDLE;
        done_d    = 1'b1;
        aborted_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Batch bookkeeping: length, issue/retire counts, in-flight and error.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      len_q      <= '0;
      issued_q   <= '0;
      retired_q  <= '0;
      inflight_q <= '0;
      err_q      <= 1'b0;
    end else if (cmd_fire) begin
      len_q      <= cmd_len_i;
      issued_q   <= '0;
      retired_q  <= '0;
      inflight_q <= '0;
      err_q      <= 1'b0;
    end else begin
      if (issue_fire)  issued_q  <= issued_q + LEN_W'(1);
      if (retire_fire) retired_q <= retired_q + LEN_W'(1);
      if (issue_fire && !retire_fire)      inflight_q <= inflight_q + IW'(1);
      else if (!issue_fire && retire_fire) inflight_q <= inflight_q - IW'(1);
      if (spurious) err_q <= 1'b1;
    end
  end

endmodule : complex_dot_scheduler

// File: tb/tb_complex_dot_scheduler.sv
// Directed bench for complex_dot_scheduler with a small in-order engine
// model (fixed latency, holds its head result under backpressure).
module tb_complex_dot_scheduler;

  localparam int SIZE         = 16;
  localparam int MAX_INFLIGHT = 8;
  localparam int LEN_W        = 16;
  localparam int OPW          = SIZE * 4 * 64;
  localparam int LAT          = 4;

  logic              clk;
  logic              rst_n;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [LEN_W-1:0]  cmd_len;
  logic              abort;
  logic              op_valid;
  logic              op_ready;
  logic [OPW-1:0]    op_data;
  logic              eng_valid;
  logic              eng_ready;
  logic [OPW-1:0]    eng_operands;
  logic              eng_flush;
  logic              eng_res_valid;
  logic              eng_res_ready;
  logic [127:0]      eng_res;
  logic              res_valid;
  logic              res_ready;
  logic [127:0]      res_data;
  logic [LEN_W-1:0]  res_idx;
  logic              busy;
  logic              done;
  logic              aborted;
  logic              err;

  logic              model_en;
  logic              mdl_valid;
  logic [127:0]      mdl_data;
  logic              inj_valid;
  logic [127:0]      inj_data;

  int checks = 0;
  int errors = 0;

  assign eng_res_valid = model_en ? mdl_valid : inj_valid;
  assign eng_res       = model_en ? mdl_data  : inj_data;

  complex_dot_scheduler #(
    .SIZE(SIZE), .MAX_INFLIGHT(MAX_INFLIGHT), .LEN_W(LEN_W)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_len_i(cmd_len),
    .abort_i(abort),
    .op_valid_i(op_valid), .op_ready_o(op_ready), .op_data_i(op_data),
    .eng_valid_o(eng_valid), .eng_ready_i(eng_ready),
    .eng_operands_o(eng_operands), .eng_flush_o(eng_flush),
    .eng_res_valid_i(eng_res_valid), .eng_res_ready_o(eng_res_ready),
    .eng_res_i(eng_res),
    .res_valid_o(res_valid), .res_ready_i(res_ready),
    .res_data_o(res_data), .res_idx_o(res_idx),
    .busy_o(busy), .done_o(done), .aborted_o(aborted), .err_o(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Engine model state and event logs (monotonic; tests use deltas).
  int               cyc = 0;
  int               seq = 0;
  int               mq_t[$];
  int               mq_s[$];
  int               iss_total = 0, ret_total = 0, done_total = 0;
  int               flush_total = 0, rv_total = 0, done_cyc = 0;
  logic             done_ab = 1'b0;
  int               iss_cyc_log [0:511];
  int               ret_cyc_log [0:511];
  logic [LEN_W-1:0] ret_idx_log [0:511];
  logic [127:0]     ret_data_log[0:511];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq_t.delete();
      mq_s.delete();
      seq <= 0;
    end else begin
      cyc <= cyc + 1;
      if (eng_flush) begin
        mq_t.delete();
        mq_s.delete();
      end else begin
        if (model_en && eng_res_valid && eng_res_ready && mq_t.size() > 0) begin
          void'(mq_t.pop_front());
          void'(mq_s.pop_front());
        end
        if (eng_valid && eng_ready) begin
          mq_t.push_back(cyc);
          mq_s.push_back(seq);
          seq <= seq + 1;
        end
      end
      if (cmd_valid && cmd_ready) seq <= 0;
      if (eng_valid && eng_ready) begin
        iss_cyc_log[iss_total] <= cyc;
        iss_total <= iss_total + 1;
      end
      if (res_valid && res_ready) begin
        ret_cyc_log[ret_total]  <= cyc;
        ret_idx_log[ret_total]  <= res_idx;
        ret_data_log[ret_total] <= res_data;
        ret_total <= ret_total + 1;
      end
      if (done) begin
        done_total <= done_total + 1;
        done_cyc   <= cyc;
        done_ab    <= aborted;
      end
      if (eng_flush) flush_total <= flush_total + 1;
      if (res_valid) rv_total <= rv_total + 1;
    end
  end

  // Engine result output: head job becomes valid LAT cycles after issue.
  always @(negedge clk) begin
    if (mq_t.size() > 0 && cyc >= mq_t[0] + LAT) begin
      mdl_valid <= 1'b1;
      mdl_data  <= {64'(mq_s[0] + 256), 64'(mq_s[0] * 3)};
    end else begin
      mdl_valid <= 1'b0;
      mdl_data  <= '0;
    end
  end

  task automatic send_cmd(input int n);
    @(negedge clk);
    cmd_len   = LEN_W'(n);
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int base, input int max_cyc, input string name);
    int k = 0;
    while (done_total == base && k < max_cyc) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (done_total == base) begin
      errors++;
      $display("FAIL %s_timeout: no done pulse within %0d cycles", name, max_cyc);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    op_valid  = 1'b1;
    eng_ready = 1'b1;
    #1;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if ({eng_valid, op_ready, eng_res_ready, res_valid} !== 4'b0000) begin
      errors++; $display("FAIL reset_handshakes: got %b want 0000", {eng_valid, op_ready, eng_res_ready, res_valid});
    end
    checks++; if ({done, aborted, err, eng_flush} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags: got %b want 0000", {done, aborted, err, eng_flush});
    end
    checks++; if (res_idx !== '0) begin errors++; $display("FAIL reset_res_idx: got %0d want 0", res_idx); end
    op_valid = 1'b0;
  endtask

  task automatic test_basic();
    int bi = iss_total, br = ret_total, bd = done_total;
    model_en  = 1'b1;
    op_valid  = 1'b1;
    eng_ready = 1'b1;
    res_ready = 1'b1;
    op_data   = {SIZE*4{64'h0123_4567_89AB_CDEF}};
    send_cmd(3);
    #1;
    checks++; if (eng_operands !== op_data) begin errors++; $display("FAIL basic_operands: got %h want %h", eng_operands[63:0], op_data[63:0]); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b want 1", busy); end
    wait_done(bd, 40, "basic");
    checks++; if (iss_total - bi != 3) begin errors++; $display("FAIL basic_issues: got %0d want 3", iss_total - bi); end
    for (int k = 1; k < 3; k++) begin
      checks++;
      if (iss_cyc_log[bi+k] != iss_cyc_log[bi+k-1] + 1) begin
        errors++; $display("FAIL basic_issue_gap: issue %0d at %0d want %0d", k, iss_cyc_log[bi+k], iss_cyc_log[bi+k-1] + 1);
      end
    end
    checks++; if (ret_total - br != 3) begin errors++; $display("FAIL basic_retires: got %0d want 3", ret_total - br); end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (ret_idx_log[br+k] !== LEN_W'(k) || ret_data_log[br+k] !== {64'(k + 256), 64'(k * 3)}) begin
        errors++; $display("FAIL basic_result%0d: got idx %0d data %h want idx %0d data %h", k, ret_idx_log[br+k], ret_data_log[br+k], k, {64'(k + 256), 64'(k * 3)});
      end
    end
    checks++; if (done_cyc != ret_cyc_log[br+2] + 1) begin errors++; $display("FAIL basic_done_time: got %0d want %0d", done_cyc, ret_cyc_log[br+2] + 1); end
    checks++; if (done_ab !== 1'b0) begin errors++; $display("FAIL basic_aborted: got %b want 0", done_ab); end
    #1;
    checks++; if ({done, busy} !== 2'b00) begin errors++; $display("FAIL basic_after: done/busy got %b want 00", {done, busy}); end
    op_valid = 1'b0;
  endtask

  task automatic test_inflight();
    int bi = iss_total, br = ret_total, bd = done_total;
    int peak = 0, k = 0;
    res_ready = 1'b0;
    op_valid  = 1'b1;
    send_cmd(20);
    repeat (20) begin
      @(negedge clk);
      if ((iss_total - bi) - (ret_total - br) > peak) peak = (iss_total - bi) - (ret_total - br);
    end
    #1;
    checks++; if (iss_total - bi != 8) begin errors++; $display("FAIL limit_issues: got %0d want 8", iss_total - bi); end
    checks++; if ({op_ready, eng_valid} !== 2'b00) begin errors++; $display("FAIL limit_stall: op_ready/eng_valid got %b want 00", {op_ready, eng_valid}); end
    checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL limit_res_held: got %b want 1", res_valid); end
    res_ready = 1'b1;
    while (done_total == bd && k < 300) begin
      @(negedge clk);
      if ((iss_total - bi) - (ret_total - br) > peak) peak = (iss_total - bi) - (ret_total - br);
      k++;
    end
    checks++; if (done_total == bd) begin errors++; $display("FAIL limit_timeout: no done within 300 cycles"); end
    checks++; if (iss_total - bi != 20 || ret_total - br != 20) begin
      errors++; $display("FAIL limit_totals: got %0d issues %0d retires want 20 20", iss_total - bi, ret_total - br);
    end
    checks++; if (peak != MAX_INFLIGHT) begin errors++; $display("FAIL limit_peak: got %0d want %0d", peak, MAX_INFLIGHT); end
    for (int j = 0; j < 20; j++) begin
      checks++;
      if (ret_idx_log[br+j] !== LEN_W'(j) || ret_data_log[br+j] !== {64'(j + 256), 64'(j * 3)}) begin
        errors++; $display("FAIL limit_result%0d: got idx %0d want %0d", j, ret_idx_log[br+j], j);
      end
    end
    checks++; if (done_ab !== 1'b0) begin errors++; $display("FAIL limit_aborted: got %b want 0", done_ab); end
    op_valid = 1'b0;
  endtask

  task automatic test_zero_len();
    int bi = iss_total, bd = done_total;
    op_valid = 1'b1;
    send_cmd(0);
    #1;
    checks++; if ({done, aborted, busy, eng_valid} !== 4'b1000) begin
      errors++; $display("FAIL zero_done: done/aborted/busy/eng_valid got %b want 1000", {done, aborted, busy, eng_valid});
    end
    @(negedge clk); #1;
    checks++; if ({done, busy, cmd_ready} !== 3'b001) begin
      errors++; $display("FAIL zero_after: done/busy/cmd_ready got %b want 001", {done, busy, cmd_ready});
    end
    checks++; if (iss_total != bi || done_total != bd + 1) begin
      errors++; $display("FAIL zero_counts: issues %0d done %0d want 0 1", iss_total - bi, done_total - bd);
    end
    op_valid = 1'b0;
  endtask

  task automatic test_abort_drain();
    int bi = iss_total, br = ret_total, bf = flush_total;
    int rvb, k = 0;
    res_ready = 1'b0;
    op_valid  = 1'b1;
    send_cmd(4);
    #1;
    while (res_valid !== 1'b1 && k < 30) begin
      @(negedge clk); #1;
      k++;
    end
    checks++; if (res_valid !== 1'b1 || iss_total - bi != 4) begin
      errors++; $display("FAIL abort_setup: res_valid %b issues %0d want 1 4", res_valid, iss_total - bi);
    end
    op_valid  = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    res_ready = 1'b0;
    abort     = 1'b1;
    #1;
    checks++; if (ret_total - br != 2) begin errors++; $display("FAIL abort_retired: got %0d want 2", ret_total - br); end
    @(negedge clk);
    abort = 1'b0;
    rvb   = rv_total;
    #1;
    checks++; if ({eng_flush, eng_res_ready, res_valid, op_ready, cmd_ready} !== 5'b11000) begin
      errors++; $display("FAIL abort_flush: flush/eres_ready/res_valid/op_ready/cmd_ready got %b want 11000", {eng_flush, eng_res_ready, res_valid, op_ready, cmd_ready});
    end
    @(negedge clk); #1;
    checks++; if ({done, aborted, cmd_ready, eng_flush} !== 4'b1110) begin
      errors++; $display("FAIL abort_done: done/aborted/cmd_ready/flush got %b want 1110", {done, aborted, cmd_ready, eng_flush});
    end
    res_ready = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    checks++; if (rv_total != rvb || ret_total - br != 2) begin
      errors++; $display("FAIL abort_no_results: res_valid cycles %0d retires %0d want 0 2", rv_total - rvb, ret_total - br);
    end
    checks++; if (flush_total - bf != 1) begin errors++; $display("FAIL abort_flush_count: got %0d want 1", flush_total - bf); end
    checks++; if ({done, aborted} !== 2'b00) begin errors++; $display("FAIL abort_pulse_len: done/aborted got %b want 00", {done, aborted}); end
  endtask

  task automatic test_spurious();
    int rvb;
    model_en  = 1'b0;
    inj_valid = 1'b0;
    inj_data  = {64'hDEAD, 64'hBEEF};
    op_valid  = 1'b0;
    res_ready = 1'b1;
    send_cmd(2);
    #1;
    checks++; if ({busy, err} !== 2'b10) begin errors++; $display("FAIL spur_setup: busy/err got %b want 10", {busy, err}); end
    rvb = rv_total;
    @(negedge clk);
    inj_valid = 1'b1;
    #1;
    checks++; if ({res_valid, eng_res_ready} !== 2'b01) begin
      errors++; $display("FAIL spur_drop: res_valid/eng_res_ready got %b want 01", {res_valid, eng_res_ready});
    end
    @(negedge clk);
    inj_valid = 1'b0;
    #1;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL spur_err_set: got %b want 1", err); end
    repeat (3) @(negedge clk);
    #1;
    checks++; if (err !== 1'b1 || rv_total != rvb) begin
      errors++; $display("FAIL spur_sticky: err %b res_valid cycles %0d want 1 0", err, rv_total - rvb);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    @(negedge clk); #1;
    checks++; if ({err, done, aborted} !== 3'b111) begin
      errors++; $display("FAIL spur_after_abort: err/done/aborted got %b want 111", {err, done, aborted});
    end
    send_cmd(0);
    #1;
    checks++; if ({err, done} !== 2'b01) begin errors++; $display("FAIL spur_err_clear: err/done got %b want 01", {err, done}); end
    model_en = 1'b1;
  endtask

  task automatic test_async_reset();
    int bi = iss_total, bf = flush_total, br, bd, k = 0;
    model_en  = 1'b1;
    res_ready = 1'b0;
    op_valid  = 1'b1;
    send_cmd(10);
    while (iss_total - bi < 5 && k < 20) begin
      @(negedge clk);
      k++;
    end
    op_valid = 1'b0;
    checks++; if (iss_total - bi != 5) begin errors++; $display("FAIL rst_setup_issues: got %0d want 5", iss_total - bi); end
    repeat (6) @(negedge clk);
    op_valid = 1'b1;
    #1;
    checks++; if ({busy, eng_valid, res_valid} !== 3'b111) begin
      errors++; $display("FAIL rst_pre: busy/eng_valid/res_valid got %b want 111", {busy, eng_valid, res_valid});
    end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({busy, eng_valid, res_valid, eng_res_ready} !== 4'b0000) begin
      errors++; $display("FAIL rst_drop: busy/eng_valid/res_valid/eres_ready got %b want 0000", {busy, eng_valid, res_valid, eng_res_ready});
    end
    checks++; if ({cmd_ready, eng_flush, done, err} !== 4'b1000) begin
      errors++; $display("FAIL rst_flags: cmd_ready/flush/done/err got %b want 1000", {cmd_ready, eng_flush, done, err});
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (cmd_ready !== 1'b1 || res_idx !== '0) begin
      errors++; $display("FAIL rst_release: cmd_ready %b res_idx %0d want 1 0", cmd_ready, res_idx);
    end
    checks++; if (flush_total != bf) begin errors++; $display("FAIL rst_no_flush: got %0d flushes want 0", flush_total - bf); end
    br = ret_total;
    bd = done_total;
    res_ready = 1'b1;
    send_cmd(2);
    wait_done(bd, 40, "rst_rerun");
    checks++; if (ret_total - br != 2 || ret_idx_log[br] !== 0 || ret_idx_log[br+1] !== 1) begin
      errors++; $display("FAIL rst_rerun_idx: retires %0d idx %0d,%0d want 2 0,1", ret_total - br, ret_idx_log[br], ret_idx_log[br+1]);
    end
    op_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_len   = '0;
    abort     = 1'b0;
    op_valid  = 1'b0;
    op_data   = '0;
    eng_ready = 1'b0;
    res_ready = 1'b0;
    model_en  = 1'b1;
    inj_valid = 1'b0;
    inj_data  = '0;
    #23 rst_n = 1'b1;
    test_reset();
    test_basic();
    test_inflight();
    test_zero_len();
    test_abort_drain();
    test_spurious();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_complex_dot_scheduler
